judge_hp_unit: RTL and testbench
================================

// Module: judge_hp_unit
// PURPOSE
//  Responder side of the game-controller status interface. Watches the 4-bit STATE code
//  broadcast by the game controller, judges factor-pair answers and the opponent's result,
//  and returns WRONG/JUDG/HP_STAT, which the controller uses to pick its next state.
//  It also owns both players' hit points.
// PARAMETERS
//  NUM_W     8           width of each entered factor; product width is 2*NUM_W
//  HP_W      3           hit-point counter width
//  HP_INIT   3           starting HP for each player; must be >0 and fit in HP_W
//  DRAW_WIN  25_000_000  cycles in which a second correct answer makes a draw (0.5 s @ 50 MHz)
// PORTS
//  CLK        in   1        system clock, 50 MHz
//  RST        in   1        synchronous, active-high reset
//  STATE      in   4        controller state code
//  Q_PRODUCT  in   2*NUM_W  current question's product; valid while STATE==QUESTION
//  ANS_VALID  in   1        1-cycle pulse: local answer presented
//  ANS_A      in   NUM_W    local factor A, qualified by ANS_VALID
//  ANS_B      in   NUM_W    local factor B, qualified by ANS_VALID
//  OPP_OK     in   1        1-cycle pulse: opponent answered correctly
//  WRONG      out  1        local answer incorrect
//  JUDG       out  2        00 none, 01 local won round, 10 opponent won round, 11 draw
//  HP_STAT    out  2        00 both alive, 01 opponent HP==0, 10 local HP==0
//  MY_HP      out  HP_W     local HP, for display
//  OPP_HP     out  HP_W     opponent HP, for display
// BEHAVIOUR
//  State codes: READY=2, QUESTION=3, INPUT=4, DRAW=6, WRONG=7, GOOD=8, OUCH=9, WIN=10, LOSE=11.
//  Reset: WRONG=0, JUDG=00, HP_STAT=00, MY_HP=OPP_HP=HP_INIT, product reg=0, judge FSM=IDLE.
//  Product: register Q_PRODUCT every cycle STATE==QUESTION; hold it in all other states.
//  Answers: ANS_VALID/OPP_OK are accepted only when STATE==INPUT and the judge FSM is in
//   IDLE, LOC_PEND or OPP_PEND. They are ignored at all other times.
//  Check pipeline: on ANS_VALID, register A, B. Next cycle, register
//   ok = (A>=2)&&(B>=2)&&(A*B==product), using a full 2*NUM_W-bit multiply.
//   Result acts 2 cycles after the pulse.
//   A second ANS_VALID while a check is in flight is dropped.
//  Judge FSM:
//   IDLE: ok=1 -> LOC_PEND, load window counter. ok=0 -> BAD, WRONG=1.
//    OPP_OK -> OPP_PEND, load counter. ok=1 and OPP_OK in the same cycle -> DONE, JUDG=11.
//   LOC_PEND: OPP_OK before expiry -> DONE, JUDG=11. Counter reaches DRAW_WIN-1 -> DONE, JUDG=01.
//   OPP_PEND: ok=1 before expiry -> DONE, JUDG=11. ok=0 -> stay, and pulse WRONG only if
//    STATE remains INPUT. Expiry -> DONE, JUDG=10.
//   BAD: hold WRONG=1 until STATE==WRONG is seen, then clear WRONG and go to IDLE.
//   DONE: hold JUDG until STATE leaves INPUT and is not GOOD/OUCH/DRAW/WIN/LOSE,
//    i.e. STATE==READY or QUESTION. Then JUDG=00 and go to IDLE.
//  Abort: STATE goes INPUT->QUESTION while in IDLE/LOC_PEND/OPP_PEND -> IDLE.
//   The in-flight check is discarded and the counter cleared.
//  HP update on the first cycle of each state entry (edge-detect STATE against its 1-cycle copy):
//   GOOD  -> OPP_HP-1, saturating at 0.
//   OUCH  -> MY_HP-1, saturating at 0.
//   DRAW  -> both unchanged.
//  HP_STAT is registered from the HP values one cycle after the update:
//   01 if OPP_HP==0, else 10 if MY_HP==0, else 00. OPP_HP is checked first.
//  New game: entry into READY from WIN or LOSE reloads both HP to HP_INIT; HP_STAT=00 next cycle.
//  RST mid-round: every register returns to its reset value in the next cycle, with no partial judgement.
//  Window counter: width $clog2(DRAW_WIN). Cleared whenever the FSM is not in a PEND state.
// STRUCTURE
//  Shared package game_pkg: state-code localparams (shared with the controller) and
//   JUDG/HP_STAT code constants.
//  One sub-module: factor_check, holding the 2-stage register, multiply and compare pipeline
//   (ANS_VALID in, ok_valid/ok out).
//  FSM, window counter and HP registers live at top level.
// TESTING
//  1 Q_PRODUCT=221, INPUT, ANS 13x17, no OPP_OK -> JUDG=01 after DRAW_WIN+2 cycles; STATE=GOOD -> OPP_HP 3->2.
//  2 ANS 1x221 -> WRONG=1 at cycle +2, held; STATE=WRONG -> WRONG=0; ANS 17x13 then accepted.
//  3 OPP_OK, then ANS 13x17 at DRAW_WIN/2 -> JUDG=11; STATE=DRAW -> HP unchanged.
//  4 OPP_OK only -> JUDG=10 at expiry; three OUCH rounds -> MY_HP=0, HP_STAT=10; further OUCH keeps MY_HP=0.
//  5 OPP_HP=1, GOOD -> OPP_HP=0, HP_STAT=01; STATE WIN->READY -> both HP=3, HP_STAT=00.
//  6 ANS_VALID then STATE INPUT->QUESTION next cycle -> no WRONG/JUDG; RST asserted in LOC_PEND -> all outputs at reset values.

Source files
------------

// File: rtl/game_pkg.sv
// Codes shared between the game controller and the responder: controller state
// codes, judgement/HP status encodings and the judge FSM state type.
package game_pkg;

    localparam logic [3:0] ST_READY    = 4'd2;
    localparam logic [3:0] ST_QUESTION = 4'd3;
    localparam logic [3:0] ST_INPUT    = 4'd4;
    localparam logic [3:0] ST_DRAW     = 4'd6;
    localparam logic [3:0] ST_WRONG    = 4'd7;
    localparam logic [3:0] ST_GOOD     = 4'd8;
    localparam logic [3:0] ST_OUCH     = 4'd9;
    localparam logic [3:0] ST_WIN      = 4'd10;
    localparam logic [3:0] ST_LOSE     = 4'd11;

    localparam logic [1:0] JUDG_NONE  = 2'b00;
    localparam logic [1:0] JUDG_LOCAL = 2'b01;
    localparam logic [1:0] JUDG_OPP   = 2'b10;
    localparam logic [1:0] JUDG_DRAW  = 2'b11;

    localparam logic [1:0] HPS_ALIVE    = 2'b00;
    localparam logic [1:0] HPS_OPP_DOWN = 2'b01;
    localparam logic [1:0] HPS_MY_DOWN  = 2'b10;

    typedef enum logic [2:0] {
        J_IDLE,
        J_LOC_PEND,
        J_OPP_PEND,
        J_BAD,
        J_DONE
    } judge_state_t;

endpackage

// File: rtl/judge_hp_unit_factor_check.sv
// Two-stage answer checker: stage 1 captures the factors, stage 2 registers
// whether both are >=2 and their full-width product matches the question.
module factor_check #(
    parameter int NUM_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NUM_W-1:0]   i_a,
    input  logic [NUM_W-1:0]   i_b,
    input  logic [2*NUM_W-1:0] i_product,
    output logic               o_busy,
    output logic               o_ok_valid,
    output logic               o_ok
);

    localparam int PW = 2 * NUM_W;
    localparam logic [NUM_W-1:0] MIN_FACTOR = NUM_W'(2);

    logic             r_v1;
    logic [NUM_W-1:0] r_a;
    logic [NUM_W-1:0] r_b;
    logic             r_ok_valid;
    logic             r_ok;
    logic [PW-1:0]    w_prod_calc;
    logic             w_ok_calc;
    logic             w_take;

    assign w_prod_calc = PW'(r_a) * PW'(r_b);
    assign w_ok_calc   = (r_a >= MIN_FACTOR) && (r_b >= MIN_FACTOR) && (w_prod_calc == i_product);
    // Only one check may be in flight; later pulses are dropped, not queued.
    assign w_take      = i_valid && !o_busy;

    always_ff @(posedge CLK) begin
        if (RST || i_flush) begin
            r_v1       <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_ok_valid <= 1'b0;
            r_ok       <= 1'b0;
        end else begin
            r_v1 <= w_take;
            if (w_take) begin
                r_a <= i_a;
                r_b <= i_b;
            end
            r_ok_valid <= r_v1;
            r_ok       <= r_v1 && w_ok_calc;
        end
    end

    assign o_busy     = r_v1 || r_ok_valid;
    assign o_ok_valid = r_ok_valid;
    assign o_ok       = r_ok;

endmodule

// File: rtl/judge_hp_unit.sv
// Responder side of the controller status link: judges local/opponent answers
// into WRONG/JUDG and keeps both players' hit points and the HP status code.
module judge_hp_unit
    import game_pkg::*;
#(
    parameter int NUM_W    = 8,
    parameter int HP_W     = 3,
    parameter int HP_INIT  = 3,
    parameter int DRAW_WIN = 25_000_000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [3:0]         STATE,
    input  logic [2*NUM_W-1:0] Q_PRODUCT,
    input  logic               ANS_VALID,
    input  logic [NUM_W-1:0]   ANS_A,
    input  logic [NUM_W-1:0]   ANS_B,
    input  logic               OPP_OK,
    output logic               WRONG,
    output logic [1:0]         JUDG,
    output logic [1:0]         HP_STAT,
    output logic [HP_W-1:0]    MY_HP,
    output logic [HP_W-1:0]    OPP_HP
);

    localparam int CNT_W = (DRAW_WIN > 2) ? $clog2(DRAW_WIN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DRAW_WIN - 1);
    localparam logic [HP_W-1:0]  HP_RELOAD = HP_W'(HP_INIT);

    logic [3:0]         r_state_prev;
    logic [2*NUM_W-1:0] r_product;
    judge_state_t       r_fsm;
    judge_state_t       w_fsm_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wrong;
    logic               w_wrong_next;
    logic [1:0]         r_judg;
    logic [1:0]         w_judg_next;
    logic [HP_W-1:0]    r_my_hp;
    logic [HP_W-1:0]    r_opp_hp;
    logic [1:0]         r_hp_stat;

    logic w_in_input;
    logic w_accepting;
    logic w_abort;
    logic w_ans_acc;
    logic w_opp_acc;
    logic w_flush;
    logic w_busy;
    logic w_ok_valid;
    logic w_ok;
    logic w_loc_hit;
    logic w_loc_miss;
    logic w_expired;
    logic w_pend;
    logic w_entry;

    assign w_in_input  = (STATE == ST_INPUT);
    assign w_accepting = (r_fsm == J_IDLE) || (r_fsm == J_LOC_PEND) || (r_fsm == J_OPP_PEND);
    // Controller fell back to QUESTION mid-answer: drop everything for this round.
    assign w_abort     = w_accepting && (r_state_prev == ST_INPUT) && (STATE == ST_QUESTION);
    assign w_ans_acc   = ANS_VALID && w_in_input && w_accepting;
    assign w_opp_acc   = OPP_OK && w_in_input && w_accepting;
    assign w_flush     = w_abort || !w_accepting;
    assign w_loc_hit   = w_ok_valid && w_ok;
    assign w_loc_miss  = w_ok_valid && !w_ok;
    assign w_expired   = (r_cnt == CNT_LAST);
    assign w_pend      = (r_fsm == J_LOC_PEND) || (r_fsm == J_OPP_PEND);
    assign w_entry     = (STATE != r_state_prev);

    factor_check #(
        .NUM_W(NUM_W)
    ) u_factor_check (
        .CLK       (CLK),
        .RST       (RST),
        .i_flush   (w_flush),
        .i_valid   (w_ans_acc),
        .i_a       (ANS_A),
        .i_b       (ANS_B),
        .i_product (r_product),
        .o_busy    (w_busy),
        .o_ok_valid(w_ok_valid),
        .o_ok      (w_ok)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fsm   <= J_IDLE;
            r_wrong <= 1'b0;
            r_judg  <= JUDG_NONE;
            r_cnt   <= '0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_wrong <= w_wrong_next;
            r_judg  <= w_judg_next;
            if (w_pend && (w_fsm_next == r_fsm))
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_fsm_next   = r_fsm;
        w_wrong_next = 1'b0;
        w_judg_next  = r_judg;
        case (r_fsm)
            J_IDLE: begin
                w_judg_next = JUDG_NONE;
                if (!w_abort) begin
                    if (w_loc_hit && w_opp_acc) begin
                        w_fsm_next  = J_DONE;
                        w_judg_next = JUDG_DRAW;
                    end else if (w_opp_acc) begin
                        w_fsm_next   = J_OPP_PEND;
                        w_wrong_next = w_loc_miss;
                    end else if (w_loc_hit) begin
                        w_fsm_next = J_LOC_PEND;
                    end else if (w_loc_miss) begin
                        w_fsm_next   = J_BAD;
                        w_wrong_next = 1'b1;
                    end
                end
            end
            J_LOC_PEND: begin
                if (w_abort) begin
                    w_fsm_next = J_IDLE;
                end else if (w_opp_acc) begin
                    w_fsm_next  = J_DONE;
                    w_judg_next = JUDG_DRAW;
                end else if (w_expired) begin
                    w_fsm_next  = J_DONE;
                    w_judg_next = JUDG_LOCAL;
                end
            end
            J_OPP_PEND: begin
                if (w_abort) begin
                    w_fsm_next = J_IDLE;
                end else if (w_loc_hit) begin
                    w_fsm_next  = J_DONE;
                    w_judg_next = JUDG_DRAW;
                end else begin
                    w_wrong_next = w_loc_miss && w_in_input;
                    if (w_expired) begin
                        w_fsm_next  = J_DONE;
                        w_judg_next = JUDG_OPP;
                    end
                end
            end
            J_BAD: begin
                if (STATE == ST_WRONG)
                    w_fsm_next = J_IDLE;
                else
                    w_wrong_next = 1'b1;
            end
            J_DONE: begin
                // Keep the verdict until the controller is back to READY/QUESTION.
                if ((STATE == ST_READY) || (STATE == ST_QUESTION)) begin
                    w_fsm_next  = J_IDLE;
                    w_judg_next = JUDG_NONE;
                end
            end
            default: begin
                w_fsm_next  = J_IDLE;
                w_judg_next = JUDG_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_prev <= 4'd0;
            r_product    <= '0;
            r_my_hp      <= HP_RELOAD;
            r_opp_hp     <= HP_RELOAD;
            r_hp_stat    <= HPS_ALIVE;
        end else begin
            r_state_prev <= STATE;
            if (STATE == ST_QUESTION)
                r_product <= Q_PRODUCT;
            if (w_entry) begin
                case (STATE)
                    ST_GOOD: begin
                        if (r_opp_hp != '0)
                            r_opp_hp <= r_opp_hp - HP_W'(1);
                    end
                    ST_OUCH: begin
                        if (r_my_hp != '0)
                            r_my_hp <= r_my_hp - HP_W'(1);
                    end
                    ST_READY: begin
                        if ((r_state_prev == ST_WIN) || (r_state_prev == ST_LOSE)) begin
                            r_my_hp  <= HP_RELOAD;
                            r_opp_hp <= HP_RELOAD;
                        end
                    end
                    default: ;
                endcase
            end
            if (r_opp_hp == '0)
                r_hp_stat <= HPS_OPP_DOWN;
            else if (r_my_hp == '0)
                r_hp_stat <= HPS_MY_DOWN;
            else
                r_hp_stat <= HPS_ALIVE;
        end
    end

    assign WRONG   = r_wrong;
    assign JUDG    = r_judg;
    assign HP_STAT = r_hp_stat;
    assign MY_HP   = r_my_hp;
    assign OPP_HP  = r_opp_hp;

endmodule

// File: tb/tb_judge_hp_unit.sv
// Bench for judge_hp_unit: table of rounds, hand-written corner sequences and
// random rounds checked against a cycle-level outcome model and an HP scoreboard.
module tb_judge_hp_unit;
    import game_pkg::*;

    localparam int NUM_W    = 8;
    localparam int HP_W     = 3;
    localparam int HP_INIT  = 3;
    localparam int DRAW_WIN = 20;
    localparam int LOGN     = 128;

    logic               CLK = 1'b0;
    logic               RST;
    logic [3:0]         STATE;
    logic [2*NUM_W-1:0] Q_PRODUCT;
    logic               ANS_VALID;
    logic [NUM_W-1:0]   ANS_A;
    logic [NUM_W-1:0]   ANS_B;
    logic               OPP_OK;
    logic               WRONG;
    logic [1:0]         JUDG;
    logic [1:0]         HP_STAT;
    logic [HP_W-1:0]    MY_HP;
    logic [HP_W-1:0]    OPP_HP;

    int n_pass  = 0;
    int n_total = 0;
    int m_my    = HP_INIT;
    int m_opp   = HP_INIT;
    int log_w[LOGN];
    int log_j[LOGN];

    typedef struct {
        int a;
        int b;
        int p;
        int t_ans;
        int t_opp;
        int exp_cyc;
        int exp_code;   // 4 = WRONG, otherwise the JUDG code
    } vec_t;
    vec_t tbl[10];

    always #5 CLK = ~CLK;

    judge_hp_unit #(
        .NUM_W(NUM_W), .HP_W(HP_W), .HP_INIT(HP_INIT), .DRAW_WIN(DRAW_WIN)
    ) dut (
        .CLK(CLK), .RST(RST), .STATE(STATE), .Q_PRODUCT(Q_PRODUCT),
        .ANS_VALID(ANS_VALID), .ANS_A(ANS_A), .ANS_B(ANS_B), .OPP_OK(OPP_OK),
        .WRONG(WRONG), .JUDG(JUDG), .HP_STAT(HP_STAT), .MY_HP(MY_HP), .OPP_HP(OPP_HP)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_state(input logic [3:0] s, input int n);
        STATE = s;
        repeat (n) tick();
    endtask

    function automatic int hp_code();
        if (m_opp == 0) return 1;
        if (m_my == 0) return 2;
        return 0;
    endfunction

    task automatic check_hp(input string tag);
        check({tag, " MY_HP"}, int'(MY_HP), m_my);
        check({tag, " OPP_HP"}, int'(OPP_HP), m_opp);
        check({tag, " HP_STAT"}, int'(HP_STAT), hp_code());
    endtask

    // Outcome from the game rules: the local result lands 2 cycles after its
    // pulse; a second correct answer within DRAW_WIN cycles of the first draws.
    function automatic void model(input int t_ans, input bit ans_ok, input int t_opp,
                                  output int cyc, output int code);
        int lr;
        lr = t_ans + 2;
        if (t_ans < 0) begin
            cyc = t_opp + DRAW_WIN; code = 2;
        end else if (!ans_ok) begin
            cyc = lr; code = 4;
        end else if (t_opp < 0) begin
            cyc = lr + DRAW_WIN; code = 1;
        end else if (lr <= t_opp) begin
            if (t_opp - lr <= DRAW_WIN) begin cyc = t_opp; code = 3; end
            else begin cyc = lr + DRAW_WIN; code = 1; end
        end else begin
            if (lr - t_opp <= DRAW_WIN) begin cyc = lr; code = 3; end
            else begin cyc = t_opp + DRAW_WIN; code = 2; end
        end
    endfunction

    task automatic play(input int a, input int b, input int p, input int t_ans,
                        input int t_opp, input int ncyc);
        Q_PRODUCT = 16'(p);
        set_state(ST_QUESTION, 2);
        Q_PRODUCT = 16'($urandom);
        STATE = ST_INPUT;
        ANS_A = 8'(a);
        ANS_B = 8'(b);
        for (int c = 0; c < ncyc && c < LOGN; c++) begin
            ANS_VALID = (c == t_ans);
            OPP_OK    = (c == t_opp);
            tick();
            log_w[c] = int'(WRONG);
            log_j[c] = int'(JUDG);
        end
        ANS_VALID = 1'b0;
        OPP_OK    = 1'b0;
    endtask

    task automatic resolve(input string name, input int code);
        case (code)
            4: begin
                set_state(ST_WRONG, 2);
                check({name, " WRONG cleared"}, int'(WRONG), 0);
            end
            1: begin
                set_state(ST_GOOD, 2);
                if (m_opp > 0) m_opp--;
            end
            2: begin
                set_state(ST_OUCH, 2);
                if (m_my > 0) m_my--;
            end
            default: set_state(ST_DRAW, 2);
        endcase
        check_hp(name);
        set_state(ST_READY, 2);
        check({name, " JUDG cleared"}, int'(JUDG), 0);
    endtask

    task automatic round(input string name, input int a, input int b, input int p,
                         input int t_ans, input int t_opp, input int exp_cyc, input int exp_code);
        int first;
        int code;
        first = -1;
        code  = 0;
        play(a, b, p, t_ans, t_opp, exp_cyc + 3);
        for (int c = 0; c < exp_cyc + 3 && c < LOGN; c++) begin
            if (first < 0 && (log_w[c] != 0 || log_j[c] != 0)) begin
                first = c;
                code  = log_w[c] * 4 + log_j[c];
            end
        end
        $display("round %s: %0dx%0d vs %0d ans@%0d opp@%0d -> code %0d at %0d (want %0d at %0d)",
                 name, a, b, p, t_ans, t_opp, code, first, exp_code, exp_cyc);
        check({name, " event cycle"}, first, exp_cyc);
        check({name, " event code"}, code, exp_code);
        resolve(name, exp_code);
    endtask

    task automatic new_game(input logic [3:0] end_state);
        set_state(end_state, 2);
        set_state(ST_READY, 2);
        m_my  = HP_INIT;
        m_opp = HP_INIT;
        check_hp("new game");
    endtask

    initial begin
        int seen;
        int guard;
        RST = 1'b1; STATE = ST_READY; Q_PRODUCT = '0; ANS_VALID = 1'b0;
        ANS_A = '0; ANS_B = '0; OPP_OK = 1'b0;

        tbl[0] = '{13, 17, 221, 0, -1, DRAW_WIN + 2, 1};
        tbl[1] = '{1, 221, 221, 0, -1, 2, 4};
        tbl[2] = '{17, 13, 221, 0, -1, DRAW_WIN + 2, 1};
        tbl[3] = '{13, 17, 221, DRAW_WIN / 2, 0, DRAW_WIN / 2 + 2, 3};
        tbl[4] = '{0, 0, 0, 0, -1, 2, 4};
        tbl[5] = '{2, 2, 4, 0, -1, DRAW_WIN + 2, 1};
        tbl[6] = '{16, 16, 256, 3, -1, DRAW_WIN + 5, 1};
        tbl[7] = '{255, 255, 65025, 0, 0, 2, 3};
        tbl[8] = '{3, 5, 16, 0, -1, 2, 4};
        tbl[9] = '{7, 9, 63, 0, 2, 2, 3};

        repeat (3) tick();
        check("reset WRONG", int'(WRONG), 0);
        check("reset JUDG", int'(JUDG), 0);
        check("reset HP_STAT", int'(HP_STAT), 0);
        check("reset MY_HP", int'(MY_HP), HP_INIT);
        check("reset OPP_HP", int'(OPP_HP), HP_INIT);
        RST = 1'b0;
        tick();

        foreach (tbl[i])
            round($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].p,
                  tbl[i].t_ans, tbl[i].t_opp, tbl[i].exp_cyc, tbl[i].exp_code);
        new_game(ST_WIN);

        // Wrong local answer while the opponent's answer is pending.
        play(3, 5, 16, 3, 0, DRAW_WIN + 3);
        check("opp_pend WRONG pulse", log_w[5], 1);
        check("opp_pend WRONG drop", log_w[6], 0);
        check("opp_pend JUDG early", log_j[DRAW_WIN - 1], 0);
        check("opp_pend JUDG expiry", log_j[DRAW_WIN], 2);
        resolve("opp_pend", 2);

        // Lose all HP, then OUCH must saturate.
        while (m_my > 0) round("ouch", 0, 0, 1, -1, 0, DRAW_WIN, 2);
        check("t4 MY_HP zero", int'(MY_HP), 0);
        check("t4 HP_STAT", int'(HP_STAT), 2);
        set_state(ST_OUCH, 2);
        check("t4 MY_HP saturates", int'(MY_HP), 0);
        new_game(ST_LOSE);

        guard = 0;
        while (m_opp > 0 && guard < 8) begin
            round("kill", 13, 17, 221, 0, -1, DRAW_WIN + 2, 1);
            guard++;
        end
        check("t5 OPP_HP zero", int'(OPP_HP), 0);
        check("t5 HP_STAT", int'(HP_STAT), 1);
        new_game(ST_WIN);

        // Abort one cycle after the answer pulse.
        Q_PRODUCT = 16'd221;
        set_state(ST_QUESTION, 2);
        STATE = ST_INPUT; ANS_A = 8'd13; ANS_B = 8'd17; ANS_VALID = 1'b1;
        tick();
        ANS_VALID = 1'b0; STATE = ST_QUESTION;
        tick();
        STATE = ST_INPUT;
        seen = 0;
        repeat (DRAW_WIN + 5) begin
            tick();
            if (WRONG || JUDG != 2'b00) seen = 1;
        end
        check("abort no judgement", seen, 0);
        set_state(ST_READY, 2);

        // Reset while a local answer is pending.
        round("pre-reset", 13, 17, 221, 0, -1, DRAW_WIN + 2, 1);
        play(13, 17, 221, 0, -1, 6);
        RST = 1'b1;
        tick();
        check("rst WRONG", int'(WRONG), 0);
        check("rst JUDG", int'(JUDG), 0);
        check("rst MY_HP", int'(MY_HP), HP_INIT);
        check("rst OPP_HP", int'(OPP_HP), HP_INIT);
        check("rst HP_STAT", int'(HP_STAT), 0);
        RST = 1'b0;
        m_my = HP_INIT; m_opp = HP_INIT;
        seen = 0;
        repeat (DRAW_WIN + 5) begin
            tick();
            if (WRONG || JUDG != 2'b00) seen = 1;
        end
        check("rst no partial judgement", seen, 0);
        set_state(ST_READY, 2);

        for (int r = 0; r < 12; r++) begin
            int kind, a, b, p, t_ans, t_opp, d, ec, code;
            bit ok;
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
                p = ($urandom_range(0, 1) == 1) ? a * b : int'($urandom_range(0, 65535));
                t_ans = int'($urandom_range(0, 4));
                t_opp = -1;
            end else if (kind == 1) begin
                a = 0; b = 0;
                p = int'($urandom_range(0, 65535));
                t_ans = -1;
                t_opp = int'($urandom_range(0, 4));
            end else begin
                a = int'($urandom_range(2, 255));
                b = int'($urandom_range(2, 255));
                p = a * b;
                d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DRAW_WIN - 2))
                                                : int'($urandom_range(DRAW_WIN + 2, DRAW_WIN + 8));
                if ($urandom_range(0, 1) == 1) begin
                    t_ans = int'($urandom_range(0, 3));
                    t_opp = t_ans + 2 + d;
                end else begin
                    t_opp = int'($urandom_range(2, 5));
                    t_ans = t_opp + d - 2;
                end
            end
            ok = (a >= 2) && (b >= 2) && (a * b == p);
            model(t_ans, ok, t_opp, ec, code);
            round($sformatf("rnd%0d", r), a, b, p, t_ans, t_opp, ec, code);
            if (m_my == 0 || m_opp == 0) new_game((m_opp == 0) ? ST_WIN : ST_LOSE);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
